// File: rtl/gcd_ctrl.sv
// Mealy FSM controller for the 8-bit subtract-and-swap GCD datapath.
// Optional iteration timeout with ERR state is enabled by defining GCD_TIMEOUT_EN.
module gcd_ctrl
`ifdef GCD_TIMEOUT_EN
#(
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic x_eq_y,
  input  logic x_gt_y,
  output logic xsel,
  output logic xload,
  output logic ysel,
  output logic yload,
  output logic sub_sel,
  output logic busy,
  output logic done,
  output logic err
);

`ifdef GCD_TIMEOUT_EN
  typedef enum logic [2:0] {StIdle, StLoadY, StRun, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoadY, StRun, StDone} state_e;
`endif

  state_e state_q, state_d;
  logic   run_abort;

`ifdef GCD_TIMEOUT_EN
  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] iter_q, iter_d;

  // Abort only when a further subtraction would be needed.
  assign run_abort = (iter_q == MaxIter);

  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  always_comb begin
    iter_d = iter_q;
    if (state_q == StIdle && go) begin
      iter_d = '0;
    end else if (state_q == StRun && !x_eq_y && !run_abort) begin
      iter_d = iter_q + 1'b1;
    end
  end
`else
  assign run_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (go) state_d = StLoadY;
      StLoadY: state_d = StRun;
      StRun: begin
        if (x_eq_y) begin
          state_d = StDone;
`ifdef GCD_TIMEOUT_EN
        end else if (run_abort) begin
          state_d = StErr;
`endif
        end
      end
      StDone:  if (!go) state_d = StIdle;
`ifdef GCD_TIMEOUT_EN
      StErr:   if (!go) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    xsel    = 1'b0;
    xload   = 1'b0;
    ysel    = 1'b0;
    yload   = 1'b0;
    sub_sel = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      StIdle: begin
        if (go) begin
          xload = 1'b1;
          xsel  = 1'b1;
        end
      end
      StLoadY: begin
        busy  = 1'b1;
        yload = 1'b1;
        ysel  = 1'b1;
      end
      StRun: begin
        busy = 1'b1;
        if (!x_eq_y && !run_abort) begin
          if (x_gt_y) begin
            xload = 1'b1;
          end else begin
            yload   = 1'b1;
            sub_sel = 1'b1;
          end
        end
      end
      StDone: done = 1'b1;
`ifdef GCD_TIMEOUT_EN
      StErr: begin
        done = 1'b1;
        err  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: behavioural 8-bit datapath plus Euclid-based reference for result
// and latency (subtraction count = sum of Euclid quotients minus one).
module tb_gcd_ctrl;

  logic clk = 1'b0;
  logic reset, go, x_eq_y, x_gt_y;
  logic xsel, xload, ysel, yload, sub_sel, busy, done, err;
  logic [7:0] din, x_q, y_q, diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .x_eq_y (x_eq_y),
    .x_gt_y (x_gt_y),
    .xsel   (xsel),
    .xload  (xload),
    .ysel   (ysel),
    .yload  (yload),
    .sub_sel(sub_sel),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Datapath model (environment, not reference)
  assign diff   = sub_sel ? (y_q - x_q) : (x_q - y_q);
  assign x_eq_y = (x_q == y_q);
  assign x_gt_y = (x_q >= y_q);

  always @(posedge clk) begin
    if (xload) x_q <= xsel ? din : diff;
    if (yload) y_q <= ysel ? din : diff;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: gcd by Euclid, subtraction count from the quotient sum.
  task automatic model(input int a, input int b, output int n, output int g);
    int p, q, t;
    p = a; q = b; n = 0;
    while (q != 0) begin
      n += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    g = p;
    n = n - 1;
  endtask

  task automatic run_op(input int a, input int b, input bit hold, input bit jitter);
    int n, g, c, bad;
    bit seen;
    model(a, b, n, g);
    @(posedge clk); #1; go = 1'b1; din = 8'(a); #1;
    check_eq("accept", int'({xsel, xload, ysel, yload, busy, done}), 'b110000);
    @(posedge clk); #1; go = jitter ? 1'($urandom % 2) : hold; din = 8'(b); #1;
    check_eq("load_y", int'({xload, ysel, yload, busy, done}), 'b01110);
    c = 2; seen = 1'b0; bad = 0;
    while (!seen && c < 600) begin
      @(posedge clk); #1;
      go  = jitter ? 1'($urandom % 2) : hold;
      din = 8'($urandom);
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy || (xload && yload) || (xload && xsel) || (yload && ysel) ||
            (sub_sel && !yload)) bad++;
        c++;
      end
    end
    check_eq("done_seen", int'(seen), 1);
    check_eq("latency", c, 3 + n);
    check_eq("gcd_x", int'(x_q), g);
    check_eq("gcd_y", int'(y_q), g);
    check_eq("run_ctl", bad, 0);
    check_eq("err_low", int'(err), 0);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1; go = 1'b1; #1;
        check_eq("hold_done", int'({done, xload, yload, busy}), 'b1000);
      end
    end
    @(posedge clk); #1; go = 1'b0; #1;
    @(posedge clk); #2;
    check_eq("back_idle", int'({done, busy, xload, yload, err}), 0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; go = 1'b0; din = 8'd0;
    x_q = 8'd0; y_q = 8'd1;
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset_outs",
             int'({xsel, xload, ysel, yload, sub_sel, busy, done, err}), 0);
    reset = 1'b0;

    run_op(12, 8, 1'b0, 1'b0);
    run_op(9, 9, 1'b0, 1'b0);
    run_op(255, 1, 1'b0, 1'b0);

    // Reset in cycle 2 of a 12/8 run
    @(posedge clk); #1; go = 1'b1; din = 8'd12;
    @(posedge clk); #1; go = 1'b0; din = 8'd8;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; #1;
    check_eq("mid_reset",
             int'({xsel, xload, ysel, yload, sub_sel, busy, done, err}), 0);
    run_op(21, 14, 1'b0, 1'b0);

    run_op(30, 18, 1'b1, 1'b0);
    run_op(7, 3, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_op(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 1'b0, 1'b1);
    end

    // Zero operand
    @(posedge clk); #1; go = 1'b1; din = 8'd0;
    @(posedge clk); #1; go = 1'b0; din = 8'd5;
`ifdef GCD_TIMEOUT_EN
    cnt = 2;
    while (!done && cnt < 400) begin
      @(posedge clk); #2;
      if (!done) cnt++;
    end
    check_eq("to_latency", cnt, 258);
    check_eq("to_err", int'({err, done}), 'b11);
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (done || err) cnt++;
    end
    check_eq("zero_no_done", cnt, 0);
`endif
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; #1;
    check_eq("final_reset", int'({busy, done, err}), 0);
    run_op(100, 75, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
